// File: rtl/pc_unit.sv
// pc_unit -- program-counter / next-PC stage for the 8-bit datapath.
//
// Holds the PC, advances it one instruction per cycle while running, and
// redirects it through a small branch-target lookup table when a
// conditional branch resolves taken against the ALU zero flag. Implements
// the start/done handshake: IDLE until started, RUN until a halt
// instruction, then HALT with done asserted until the next start.
//
// Optional feature macro: PC_UNIT_INSTR_COUNT_EN
//   defined   -> 16-bit saturating retired-instruction counter on instr_count
//   undefined -> instr_count tied to 0, no counter logic
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   begin program execution (sampled in IDLE/HALT)
//   halt           in   instruction at pc is a halt
//   branch_en      in   instruction at pc is a conditional branch
//   branch_on_zero in   1: branch when alu_zero=1, 0: branch when alu_zero=0
//   alu_zero       in   ALU zero flag for the current instruction
//   branch_idx     in   LUT entry holding the branch target
//   lut_wr_en      in   LUT write strobe (honoured in IDLE/HALT only)
//   lut_wr_idx     in   LUT write address
//   lut_wr_data    in   LUT write data
//   pc             out  current instruction address
//   pc_valid       out  high in RUN
//   branch_taken   out  previous RUN cycle took a branch
//   done           out  high in HALT
//   instr_count    out  retired-instruction count
module pc_unit #(
  parameter int                  PC_WIDTH   = 10,
  parameter int                  LUT_IDX_W  = 4,
  parameter logic [PC_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic                 branch_on_zero,
  input  logic                 alu_zero,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_wr_en,
  input  logic [LUT_IDX_W-1:0] lut_wr_idx,
  input  logic [PC_WIDTH-1:0]  lut_wr_data,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_valid,
  output logic                 branch_taken,
  output logic                 done,
  output logic [15:0]          instr_count
);

  localparam int LUT_DEPTH = 1 << LUT_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic                branch_taken_q, branch_taken_d;
  logic                done_q, done_d;
  logic [PC_WIDTH-1:0] lut_q [LUT_DEPTH];
  logic                lut_wr_ok_s;

  // Next-state, next-PC and registered-output values.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_valid_d     = 1'b0;
    branch_taken_d = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          pc_d       = START_ADDR;
          pc_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Priority: halt over branch over sequential step.
        if (halt) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end else if (branch_en && (alu_zero == branch_on_zero)) begin
          pc_d           = lut_q[branch_idx];
          pc_valid_d     = 1'b1;
          branch_taken_d = 1'b1;
        end else begin
          // Natural truncation wraps the maximum address back to 0.
          pc_d       = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          pc_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d    = ST_RUN;
          pc_d       = START_ADDR;
          pc_valid_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= START_ADDR;
      pc_valid_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_valid_q     <= pc_valid_d;
      branch_taken_q <= branch_taken_d;
      done_q         <= done_d;
    end
  end

  // The LUT is frozen while a program runs so a stray strobe cannot move a
  // branch target underneath executing code.
  assign lut_wr_ok_s = lut_wr_en && (state_q != ST_RUN);

  // Branch-target LUT storage, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_wr_ok_s) begin
      lut_q[lut_wr_idx] <= lut_wr_data;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign branch_taken = branch_taken_q;
  assign done         = done_q;

`ifdef PC_UNIT_INSTR_COUNT_EN
  logic [15:0] instr_count_q, instr_count_d;
  logic        start_accept_s;

  assign start_accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  // Saturating count of RUN cycles (the halt cycle retires too).
  always_comb begin
    instr_count_d = instr_count_q;
    if (start_accept_s) begin
      instr_count_d = 16'h0000;
    end else if ((state_q == ST_RUN) && (instr_count_q != 16'hFFFF)) begin
      instr_count_d = instr_count_q + 16'h0001;
    end else begin
      instr_count_d = instr_count_q;
    end
  end

  // Instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_q <= 16'h0000;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a behavioural program-counter model
// tracks what every output must be; each clock step compares all outputs
// against it, and key points are also pinned with literal expectations.
module tb_pc_unit;

  localparam int PC_WIDTH  = 10;
  localparam int LUT_IDX_W = 4;
  localparam int PC_MOD    = 1 << PC_WIDTH;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 halt;
  logic                 branch_en;
  logic                 branch_on_zero;
  logic                 alu_zero;
  logic [LUT_IDX_W-1:0] branch_idx;
  logic                 lut_wr_en;
  logic [LUT_IDX_W-1:0] lut_wr_idx;
  logic [PC_WIDTH-1:0]  lut_wr_data;
  logic [PC_WIDTH-1:0]  pc;
  logic                 pc_valid;
  logic                 branch_taken;
  logic                 done;
  logic [15:0]          instr_count;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode;
  int m_pc;
  int m_bt;
  int m_count;
  int m_lut [16];

  pc_unit #(.PC_WIDTH(PC_WIDTH), .LUT_IDX_W(LUT_IDX_W), .START_ADDR(10'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .branch_en(branch_en), .branch_on_zero(branch_on_zero), .alu_zero(alu_zero),
    .branch_idx(branch_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data), .pc(pc), .pc_valid(pc_valid),
    .branch_taken(branch_taken), .done(done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_bt    = 0;
    m_count = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic model_clock();
    if (m_mode == 1) begin
`ifdef PC_UNIT_INSTR_COUNT_EN
      if (m_count < 65535) m_count = m_count + 1;
`endif
      if (halt) begin
        m_mode = 2;
        m_bt   = 0;
      end else if (branch_en && (alu_zero == branch_on_zero)) begin
        m_pc = m_lut[branch_idx];
        m_bt = 1;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
        m_bt = 0;
      end
    end else begin
      if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
      m_bt = 0;
      if (start) begin
        m_mode  = 1;
        m_pc    = 0;
        m_count = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_valid", 32'(pc_valid), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("branch_taken", 32'(branch_taken), 32'(m_bt));
    chk("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  // One clock: model follows the edge, outputs compared 1ns later, return at negedge.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_on_zero = 1'b0;
    alu_zero = 1'b0; branch_idx = '0; lut_wr_en = 1'b0; lut_wr_idx = '0;
    lut_wr_data = '0;
  endtask

  task automatic do_branch(input logic boz, input logic az, input logic [3:0] idx);
    branch_en = 1'b1; branch_on_zero = boz; alu_zero = az; branch_idx = idx;
    step();
    branch_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_cnt;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("reset_pc_lit", 32'(pc), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // LUT[3] = 0x040 written in IDLE; pc holds.
    lut_wr_en = 1'b1; lut_wr_idx = 4'd3; lut_wr_data = 10'h040;
    step();
    lut_wr_en = 1'b0;

    // Start, then four sequential cycles: 0,1,2,3,4.
    do_start();
    chk("start_pc_lit", 32'(pc), 32'h0);
    chk("start_valid_lit", 32'(pc_valid), 32'h1);
    for (int i = 0; i < 4; i++) step();
    chk("seq_pc4_lit", 32'(pc), 32'h4);
    do_halt();

    // Taken branch from pc=2.
    do_start();
    step(); step();
    do_branch(1'b1, 1'b1, 4'd3);
    chk("br_taken_pc_lit", 32'(pc), 32'h040);
    chk("br_taken_flag_lit", 32'(branch_taken), 32'h1);
    // Not-taken branch, with an ignored LUT write during RUN.
    lut_wr_en = 1'b1; lut_wr_idx = 4'd3; lut_wr_data = 10'h123;
    do_branch(1'b1, 1'b0, 4'd3);
    lut_wr_en = 1'b0;
    // branch_on_zero=0 with alu_zero=0 is taken.
    do_branch(1'b0, 1'b0, 4'd3);
    chk("br_boz0_lut_kept_lit", 32'(pc), 32'h040);
    do_halt();

    // Not-taken branch at pc=2 steps to 3.
    do_start();
    step(); step();
    do_branch(1'b1, 1'b0, 4'd3);
    chk("br_not_taken_pc_lit", 32'(pc), 32'h3);
    chk("br_not_taken_flag_lit", 32'(branch_taken), 32'h0);
    step();
    lut_wr_en = 1'b1; lut_wr_idx = 4'd3; lut_wr_data = 10'h155;
    step();
    lut_wr_en = 1'b0;
    step(); step();
    // pc=7: halt wins over a taken branch.
    halt = 1'b1;
    do_branch(1'b1, 1'b1, 4'd3);
    halt = 1'b0;
    chk("halt_pc_lit", 32'(pc), 32'h7);
    chk("halt_done_lit", 32'(done), 32'h1);
    chk("halt_valid_lit", 32'(pc_valid), 32'h0);

    // LUT write in HALT, then restart from HALT.
    lut_wr_en = 1'b1; lut_wr_idx = 4'd5; lut_wr_data = 10'h3FE;
    step();
    lut_wr_en = 1'b0;
    do_start();
    chk("restart_pc_lit", 32'(pc), 32'h0);
    chk("restart_done_lit", 32'(done), 32'h0);
    chk("restart_valid_lit", 32'(pc_valid), 32'h1);
    do_branch(1'b1, 1'b1, 4'd3);
    chk("lut_unchanged_lit", 32'(pc), 32'h040);
    do_branch(1'b0, 1'b0, 4'd5);
    chk("br_to_3fe_lit", 32'(pc), 32'h3FE);
    step();
    step();
    chk("wrap_pc_lit", 32'(pc), 32'h0);

    // Asynchronous reset mid-run at pc=5.
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_pc_lit", 32'(pc), 32'h5);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midreset_pc_lit", 32'(pc), 32'h0);
    chk("midreset_valid_lit", 32'(pc_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_start();
    do_branch(1'b1, 1'b1, 4'd3);
    chk("lut_cleared_lit", 32'(pc), 32'h0);
    do_halt();

    // Instruction count: start, 6 sequential, halt.
    do_start();
    chk("cnt_after_start_lit", 32'(instr_count), 32'h0);
    for (int i = 0; i < 6; i++) step();
    do_halt();
`ifdef PC_UNIT_INSTR_COUNT_EN
    exp_cnt = 16'd7;
`else
    exp_cnt = 16'd0;
`endif
    chk("cnt_halt_lit", 32'(instr_count), 32'(exp_cnt));
    step(); step();
    chk("cnt_hold_lit", 32'(instr_count), 32'(exp_cnt));
    do_start();
    chk("cnt_restart_lit", 32'(instr_count), 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter / next-PC stage for the 8-bit datapath; sits downstream of the ALU and consumes its zero flag to resolve conditional branches.
- Holds the PC, steps it each cycle, and redirects it through a small branch-target lookup table (LUT) when a branch is taken.
- Runs the start/done program handshake: idle until started, runs until a halt instruction, then reports done.

Parameters:
- PC_WIDTH, 10, width of the PC and of each LUT entry.
- LUT_IDX_W, 4, width of the LUT index; depth is 2**LUT_IDX_W.
- START_ADDR, 0, PC value loaded by reset and by every accepted start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin program execution; sampled in IDLE and HALT only.
- halt  input  1  instruction at the current pc is a halt.
- branch_en  input  1  instruction at the current pc is a conditional branch.
- branch_on_zero  input  1  1: take the branch when alu_zero=1; 0: take it when alu_zero=0.
- alu_zero  input  1  zero flag from the ALU for the current instruction.
- branch_idx  input  LUT_IDX_W  LUT entry holding the branch target.
- lut_wr_en  input  1  LUT write strobe.
- lut_wr_idx  input  LUT_IDX_W  LUT write address.
- lut_wr_data  input  PC_WIDTH  LUT write data.
- pc  output  PC_WIDTH  current instruction address.
- pc_valid  output  1  high in RUN; the instruction at pc executes this cycle.
- branch_taken  output  1  registered; 1 if the previous RUN cycle took a branch.
- done  output  1  high in HALT.
- instr_count  output  16  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, RUN, HALT. All outputs are registered.
- Reset (async, immediate, also valid mid-run):
  - state=IDLE, pc=START_ADDR, pc_valid=0, done=0, branch_taken=0, instr_count=0.
  - All LUT entries clear to 0.
- IDLE:
  - pc holds.
  - start=1 -> next cycle: RUN, pc=START_ADDR, pc_valid=1.
- RUN, one instruction per cycle, priority halt > branch > sequential:
  - halt=1 -> next cycle: HALT, pc holds, pc_valid=0, done=1, branch_taken=0.
  - else branch_en=1 and condition met (alu_zero==branch_on_zero) -> pc=LUT[branch_idx], branch_taken=1.
  - else pc=pc+1 modulo 2**PC_WIDTH (the maximum address wraps to 0), branch_taken=0.
  - start is ignored in RUN.
  - branch_en=1 with the condition not met -> sequential step.
- HALT:
  - done stays 1 and pc holds.
  - start=1 -> next cycle: RUN, pc=START_ADDR, done=0, pc_valid=1.
- LUT writes:
  - Accepted only in IDLE or HALT, at the clock edge; ignored in RUN (no corruption).
  - A write in the same cycle as an accepted start is still performed.
- Latency:
  - start to first pc_valid: 1 cycle.
  - Branch resolution: same cycle; the new pc is visible after the next edge.
- Inputs other than start and the LUT write ports are don't-care outside RUN.

Optional Feature:
- Macro: PC_UNIT_INSTR_COUNT_EN.
- Defined:
  - instr_count increments once per RUN cycle, including the halt cycle.
  - Saturates at 16'hFFFF.
  - Clears to 0 on reset and on every accepted start; holds in IDLE and HALT.
- Not defined: instr_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset mid-run at pc=5 -> same cycle: pc=0, pc_valid=0, done=0, state IDLE; LUT reads 0.
- Write LUT[3]=10'h040 in IDLE; start; hold 4 cycles with no branch/halt -> pc sequence 0,1,2,3,4 with pc_valid=1.
- RUN at pc=2: branch_en=1, branch_on_zero=1, alu_zero=1, branch_idx=3 -> next pc=0x040, branch_taken=1. Repeat with alu_zero=0 -> next pc=3, branch_taken=0.
- RUN at pc=7: halt=1 and branch_en=1 with condition met -> next cycle pc=7, done=1, pc_valid=0; a lut_wr_en pulse during the preceding RUN cycles leaves the LUT unchanged.
- pc=10'h3FF with no branch -> next pc=0. In HALT, pulse start -> next cycle pc=0, done=0, pc_valid=1.
- With PC_UNIT_INSTR_COUNT_EN: start, 6 sequential cycles, then halt -> instr_count=7 and holds. Restart -> instr_count=0. Without the macro -> instr_count=0 throughout.
